// File: rtl/mips32_pkg.sv
// Shared types for the mips32 pipeline: opcodes, instruction classes,
// ALU operations, pipeline-register layouts and small decode helpers.
package mips32_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_e;

  // CLS_NOP covers bubbles, squashed slots and unknown opcodes.
  typedef enum logic [2:0] {
    CLS_NOP, CLS_RR_ALU, CLS_RM_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_HALT
  } iclass_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL, ALU_PASSA
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [8:0]  npc;
    logic [31:0] ir;
  } if_id_t;

  typedef struct packed {
    iclass_e     cls;
    alu_op_e     op;
    logic        br_on_zero;
    logic [4:0]  dst;
    logic [8:0]  npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    iclass_e     cls;
    logic [4:0]  dst;
    logic [31:0] alu_out;
    logic [31:0] b;
  } ex_mem_t;

  typedef struct packed {
    iclass_e     cls;
    logic [4:0]  dst;
    logic [31:0] alu_out;
    logic [31:0] lmd;
    logic [31:0] b;
  } mem_wb_t;

  function automatic iclass_e op_class(input logic [5:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: op_class = CLS_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     op_class = CLS_RM_ALU;
      OP_LW:                                         op_class = CLS_LOAD;
      OP_SW:                                         op_class = CLS_STORE;
      OP_BNEQZ, OP_BEQZ:                             op_class = CLS_BRANCH;
      OP_HLT:                                        op_class = CLS_HALT;
      default:                                       op_class = CLS_NOP;
    endcase
  endfunction

  // Loads/stores use ADD for address generation; branches pass rs through
  // so the zero flag reflects the tested register.
  function automatic alu_op_e op_alu(input logic [5:0] opc);
    case (opc)
      OP_SUB, OP_SUBI:   op_alu = ALU_SUB;
      OP_AND:            op_alu = ALU_AND;
      OP_OR:             op_alu = ALU_OR;
      OP_SLT, OP_SLTI:   op_alu = ALU_SLT;
      OP_MUL:            op_alu = ALU_MUL;
      OP_BNEQZ, OP_BEQZ: op_alu = ALU_PASSA;
      default:           op_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for the EX stage; o_zero feeds branch resolution.
module mips32_alu
  import mips32_pkg::*;
(
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero
);

  // Select the operation; MUL keeps the low 32 bits, identical for signed operands.
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_OR:    o_result = i_a | i_b;
      ALU_SLT:   o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
      ALU_MUL:   o_result = i_a * i_b;
      ALU_PASSA: o_result = i_a;
      default:   o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips32.sv
// Five-stage MIPS32-subset pipeline without forwarding or interlocks.
// Reg/D_Mem writes happen at WB so a halt cleanly gates every younger write.
module mips32
  import mips32_pkg::*;
(
  input  logic clk_1,
  input  logic rst,
  output logic halted
);

  logic [31:0] Reg   [0:31];
  logic [31:0] I_Mem [0:511];
  logic [31:0] D_Mem [0:511];

  logic [8:0] r_pc;
  logic       r_halted;
  if_id_t     r_if_id;
  id_ex_t     r_id_ex;
  ex_mem_t    r_ex_mem;
  mem_wb_t    r_mem_wb;

  logic [5:0]  w_opc;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  id_ex_t      w_id_ex;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_out;
  logic        w_alu_zero;
  logic        w_br_taken;
  logic [8:0]  w_br_target;
  logic [31:0] w_lmd;
  logic        w_wb_we;
  logic        w_st_we;
  logic [31:0] w_wb_data;

  assign halted = r_halted;

  // WB-side write enables, suppressed once halted.
  assign w_wb_we = !r_halted && (r_mem_wb.dst != 5'd0) &&
                   ((r_mem_wb.cls == CLS_RR_ALU) || (r_mem_wb.cls == CLS_RM_ALU) ||
                    (r_mem_wb.cls == CLS_LOAD));
  assign w_st_we   = !r_halted && (r_mem_wb.cls == CLS_STORE);
  assign w_wb_data = (r_mem_wb.cls == CLS_LOAD) ? r_mem_wb.lmd : r_mem_wb.alu_out;

  // ID register read: R0 is hardwired, and a same-cycle WB write wins.
  assign w_opc = r_if_id.ir[31:26];
  assign w_rs  = r_if_id.ir[25:21];
  assign w_rt  = r_if_id.ir[20:16];
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 :
                    (w_wb_we && (r_mem_wb.dst == w_rs)) ? w_wb_data : Reg[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 :
                    (w_wb_we && (r_mem_wb.dst == w_rt)) ? w_wb_data : Reg[w_rt];

  // Decode the IF/ID instruction into the next ID/EX contents.
  always_comb begin
    w_id_ex            = '0;
    w_id_ex.cls        = r_if_id.valid ? op_class(w_opc) : CLS_NOP;
    w_id_ex.op         = op_alu(w_opc);
    w_id_ex.br_on_zero = (w_opc == OP_BEQZ);
    w_id_ex.dst        = (w_id_ex.cls == CLS_RR_ALU) ? r_if_id.ir[15:11] : w_rt;
    w_id_ex.npc        = r_if_id.npc;
    w_id_ex.a          = w_rs_val;
    w_id_ex.b          = w_rt_val;
    w_id_ex.imm        = {{16{r_if_id.ir[15]}}, r_if_id.ir[15:0]};
  end

  // EX: R-type uses rt, everything else uses the sign-extended immediate.
  assign w_alu_b = (r_id_ex.cls == CLS_RR_ALU) ? r_id_ex.b : r_id_ex.imm;

  mips32_alu u_alu (
    .i_op     (r_id_ex.op),
    .i_a      (r_id_ex.a),
    .i_b      (w_alu_b),
    .o_result (w_alu_out),
    .o_zero   (w_alu_zero)
  );

  assign w_br_taken  = (r_id_ex.cls == CLS_BRANCH) && (r_id_ex.br_on_zero == w_alu_zero);
  assign w_br_target = r_id_ex.npc + r_id_ex.imm[8:0];

  // MEM: load data read from the EX/MEM address.
  assign w_lmd = D_Mem[r_ex_mem.alu_out[8:0]];

  // Pipeline advance; a taken branch redirects PC and squashes IF/ID and ID/EX.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_halted <= 1'b0;
      r_if_id  <= '0;
      r_id_ex  <= '0;
      r_ex_mem <= '0;
      r_mem_wb <= '0;
    end else if (!r_halted) begin
      if (r_mem_wb.cls == CLS_HALT) r_halted <= 1'b1;
      if (w_br_taken) begin
        r_pc    <= w_br_target;
        r_if_id <= '0;
        r_id_ex <= '0;
      end else begin
        r_pc          <= r_pc + 9'd1;
        r_if_id.valid <= 1'b1;
        r_if_id.npc   <= r_pc + 9'd1;
        r_if_id.ir    <= I_Mem[r_pc];
        r_id_ex       <= w_id_ex;
      end
      r_ex_mem.cls     <= r_id_ex.cls;
      r_ex_mem.dst     <= r_id_ex.dst;
      r_ex_mem.alu_out <= w_alu_out;
      r_ex_mem.b       <= r_id_ex.b;
      r_mem_wb.cls     <= r_ex_mem.cls;
      r_mem_wb.dst     <= r_ex_mem.dst;
      r_mem_wb.alu_out <= r_ex_mem.alu_out;
      r_mem_wb.lmd     <= w_lmd;
      r_mem_wb.b       <= r_ex_mem.b;
    end
  end

  // Architectural writes from WB; reset leaves the arrays untouched.
  always_ff @(posedge clk_1) begin
    if (w_wb_we) Reg[r_mem_wb.dst] <= w_wb_data;
    if (w_st_we) D_Mem[r_mem_wb.alu_out[8:0]] <= r_mem_wb.b;
  end

endmodule

// File: tb/tb_mips32.sv
// Directed bench for mips32: preloads memories hierarchically, runs short
// programs and checks architectural state against hand-computed values.
module tb_mips32;

  logic clk_1 = 1'b0;
  logic rst   = 1'b0;
  logic halted;
  int   checks = 0;
  int   errors = 0;
  int   n_edges;
  logic [31:0] exp_q[$];

  mips32 dut (
    .clk_1  (clk_1),
    .rst    (rst),
    .halted (halted)
  );

  // Clock and reset
  always #5 clk_1 = ~clk_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_all();
    rst = 1'b1;
    for (int i = 0; i < 512; i++) begin
      dut.I_Mem[i] = 32'h0;
      dut.D_Mem[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) dut.Reg[i] = 32'h0;
  endtask

  task automatic release_rst();
    @(negedge clk_1);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1);
      #1;
    end
  endtask

  task automatic run_to_halt(input int max_edges, output int n);
    n = 0;
    while (!halted && n < max_edges) begin
      step(1);
      n++;
    end
  endtask

  task automatic load_alu_prog();
    dut.I_Mem[0]  = 32'h2801000A;
    dut.I_Mem[1]  = 32'h28020014;
    dut.I_Mem[2]  = 32'h28030019;
    dut.I_Mem[3]  = 32'h0CE77800;
    dut.I_Mem[4]  = 32'h0CE77800;
    dut.I_Mem[5]  = 32'h00222000;
    dut.I_Mem[6]  = 32'h0CE77800;
    dut.I_Mem[7]  = 32'h0CE77800;
    dut.I_Mem[8]  = 32'h0CE77800;
    dut.I_Mem[9]  = 32'h00832800;
    dut.I_Mem[10] = 32'hFC000000;
  endtask

  // Scoreboard of final ALU-program register values R1..R5
  task automatic check_alu_regs(input string tag);
    exp_q = {32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
    for (int r = 1; r <= 5; r++) check($sformatf("%s_R%0d", tag, r), dut.Reg[r], exp_q.pop_front());
  endtask

  initial begin
    // ---- ALU program ----
    clear_all();
    load_alu_prog();
    step(2);
    check("reset_pc", {23'd0, dut.r_pc}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    release_rst();
    step(4);
    check("alu_R1_edge4", dut.Reg[1], 32'd0);
    step(1);
    check("alu_R1_edge5", dut.Reg[1], 32'd10);
    step(9);
    check("alu_halted_edge14", {31'd0, halted}, 32'd0);
    check("alu_R4_edge14", dut.Reg[4], 32'd30);
    step(1);
    check("alu_halted_edge15", {31'd0, halted}, 32'd1);
    check("alu_pc_edge15", {23'd0, dut.r_pc}, 32'd15);
    check_alu_regs("alu");
    step(10);
    check("alu_pc_frozen", {23'd0, dut.r_pc}, 32'd15);
    check("alu_R15_quiet", dut.Reg[15], 32'd0);
    check("alu_R5_stable", dut.Reg[5], 32'd55);

    // ---- Async reset mid-run ----
    clear_all();
    load_alu_prog();
    step(2);
    release_rst();
    step(6);
    rst = 1'b1;
    #1;
    check("arst_pc", {23'd0, dut.r_pc}, 32'd0);
    check("arst_halted", {31'd0, halted}, 32'd0);
    check("arst_R1_kept", dut.Reg[1], 32'd10);
    check("arst_R2_kept", dut.Reg[2], 32'd20);
    check("arst_R3_unwritten", dut.Reg[3], 32'd0);
    step(2);
    release_rst();
    run_to_halt(40, n_edges);
    check("arst_rerun_halt", {31'd0, halted}, 32'd1);
    check("arst_rerun_edges", n_edges, 32'd15);
    check_alu_regs("arst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_after_halt_halted", {31'd0, halted}, 32'd0);
    check("arst_after_halt_pc", {23'd0, dut.r_pc}, 32'd0);

    // ---- Load / store ----
    clear_all();
    dut.D_Mem[120] = 32'd85;
    dut.I_Mem[0]  = 32'h28010078;
    dut.I_Mem[1]  = 32'h0CE77800;
    dut.I_Mem[2]  = 32'h0CE77800;
    dut.I_Mem[3]  = 32'h20220000;
    dut.I_Mem[4]  = 32'h0CE77800;
    dut.I_Mem[5]  = 32'h0CE77800;
    dut.I_Mem[6]  = 32'h2842002D;
    dut.I_Mem[7]  = 32'h0CE77800;
    dut.I_Mem[8]  = 32'h0CE77800;
    dut.I_Mem[9]  = 32'h24220001;
    dut.I_Mem[10] = 32'hFC000000;
    step(2);
    release_rst();
    run_to_halt(40, n_edges);
    check("ls_halt", {31'd0, halted}, 32'd1);
    check("ls_edges", n_edges, 32'd15);
    check("ls_R1", dut.Reg[1], 32'd120);
    check("ls_R2", dut.Reg[2], 32'd130);
    check("ls_dmem121", dut.D_Mem[121], 32'd130);
    check("ls_dmem120", dut.D_Mem[120], 32'd85);

    // ---- Factorial ----
    clear_all();
    dut.D_Mem[200] = 32'd7;
    dut.I_Mem[0]  = 32'h200A00C8;
    dut.I_Mem[1]  = 32'h28020001;
    dut.I_Mem[2]  = 32'h0CE77800;
    dut.I_Mem[3]  = 32'h0CE77800;
    dut.I_Mem[4]  = 32'h144A1000;
    dut.I_Mem[5]  = 32'h2D4A0001;
    dut.I_Mem[6]  = 32'h0CE77800;
    dut.I_Mem[7]  = 32'h0CE77800;
    dut.I_Mem[8]  = 32'h3540FFFB;
    dut.I_Mem[9]  = 32'h240200C6;
    dut.I_Mem[10] = 32'hFC000000;
    step(2);
    release_rst();
    run_to_halt(300, n_edges);
    check("fact_halt", {31'd0, halted}, 32'd1);
    check("fact_edges", n_edges, 32'd57);
    check("fact_dmem198", dut.D_Mem[198], 32'd5040);
    check("fact_R2", dut.Reg[2], 32'd5040);
    check("fact_R10", dut.Reg[10], 32'd0);

    // ---- Branch squash and R0 ----
    clear_all();
    dut.Reg[6]  = 32'h66;
    dut.Reg[7]  = 32'h77;
    dut.Reg[11] = 32'h1111;
    dut.I_Mem[0] = 32'h38000002;
    dut.I_Mem[1] = 32'h28060001;
    dut.I_Mem[2] = 32'h28070001;
    dut.I_Mem[3] = 32'h28080001;
    dut.I_Mem[4] = 32'h28000005;
    dut.I_Mem[5] = 32'h0CE77800;
    dut.I_Mem[6] = 32'h0CE77800;
    dut.I_Mem[7] = 32'h00005800;
    dut.I_Mem[8] = 32'hFC000000;
    step(2);
    release_rst();
    run_to_halt(40, n_edges);
    check("br_halt", {31'd0, halted}, 32'd1);
    check("br_edges", n_edges, 32'd13);
    check("br_R6_squashed", dut.Reg[6], 32'h66);
    check("br_R7_squashed", dut.Reg[7], 32'h77);
    check("br_R8_target", dut.Reg[8], 32'd1);
    check("br_R0", dut.Reg[0], 32'd0);
    check("br_R11_reads_R0", dut.Reg[11], 32'd0);

    // ---- Halt gating ----
    clear_all();
    dut.Reg[9]    = 32'h99;
    dut.D_Mem[50] = 32'hABCD;
    dut.I_Mem[0]  = 32'hFC000000;
    dut.I_Mem[1]  = 32'h28090003;
    dut.I_Mem[2]  = 32'h24000032;
    step(2);
    release_rst();
    run_to_halt(40, n_edges);
    check("hg_halt", {31'd0, halted}, 32'd1);
    check("hg_edges", n_edges, 32'd5);
    check("hg_pc", {23'd0, dut.r_pc}, 32'd5);
    step(20);
    check("hg_pc_frozen", {23'd0, dut.r_pc}, 32'd5);
    check("hg_R9", dut.Reg[9], 32'h99);
    check("hg_dmem50", dut.D_Mem[50], 32'hABCD);
    check("hg_still_halted", {31'd0, halted}, 32'd1);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
